// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Collects a three-byte command (operand A, operand B, opcode)
//                from a serial receive stream, replays each byte onto the ALU
//                data bus with a one-cycle load strobe, waits a settle window,
//                then hands the ALU result to the transmitter and waits for
//                it to finish (bounded by a timeout).
//  Ports       : i_clk, i_rst         clock / async active-high reset
//                i_rx_data/i_rx_valid received byte and its one-cycle strobe
//                i_result             ALU result (signed, passed through)
//                i_tx_done            transmitter finished a byte
//                o_data_bus           data bus to the ALU
//                o_load_A/B/op        one-cycle ALU load strobes
//                o_tx_data/o_tx_start result byte and transmit request
//                o_busy               high in every state except WAIT_A
//                o_overrun            sticky: a received byte was dropped
//                o_timeout            one-cycle pulse on abandoned transmit
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int MODE_WIDTH    = 6,
    parameter int SETTLE_CYCLES = 2,
    parameter int TX_TIMEOUT    = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    input  logic [DATA_WIDTH-1:0] i_result,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_data_bus,
    output logic                  o_load_A,
    output logic                  o_load_B,
    output logic                  o_load_op,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_overrun,
    output logic                  o_timeout
);

    typedef enum logic [3:0] {
        S_WAIT_A  = 4'd0,
        S_LOAD_A  = 4'd1,
        S_WAIT_B  = 4'd2,
        S_LOAD_B  = 4'd3,
        S_WAIT_OP = 4'd4,
        S_LOAD_OP = 4'd5,
        S_SETTLE  = 4'd6,
        S_SEND    = 4'd7,
        S_WAIT_TX = 4'd8
    } state_t;

    localparam int c_to_w = $clog2(TX_TIMEOUT);

    // The timeout counter starts at 0 on the first WAIT_TX cycle; expiry is
    // taken on the cycle where it would step to TX_TIMEOUT-1.
    localparam logic [c_to_w-1:0]     c_to_last     = c_to_w'(TX_TIMEOUT - 2);
    localparam logic [3:0]            c_settle_last = 4'(SETTLE_CYCLES - 1);
    // Opcode keeps only its low MODE_WIDTH bits; the rest are forced to 0.
    localparam logic [DATA_WIDTH-1:0] c_op_mask     =
        DATA_WIDTH'((64'd1 << MODE_WIDTH) - 64'd1);

    state_t                r_state_q,      w_state_d;
    logic [DATA_WIDTH-1:0] r_data_bus_q,   w_data_bus_d;
    logic                  r_load_a_q,     w_load_a_d;
    logic                  r_load_b_q,     w_load_b_d;
    logic                  r_load_op_q,    w_load_op_d;
    logic [DATA_WIDTH-1:0] r_tx_data_q,    w_tx_data_d;
    logic                  r_tx_start_q,   w_tx_start_d;
    logic                  r_busy_q,       w_busy_d;
    logic                  r_overrun_q,    w_overrun_d;
    logic                  r_timeout_q,    w_timeout_d;
    logic [3:0]            r_settle_cnt_q, w_settle_cnt_d;
    logic [c_to_w-1:0]     r_to_cnt_q,     w_to_cnt_d;
    logic                  w_drop;

    always_comb begin
        w_state_d      = r_state_q;
        w_data_bus_d   = r_data_bus_q;
        w_load_a_d     = 1'b0;
        w_load_b_d     = 1'b0;
        w_load_op_d    = 1'b0;
        w_tx_data_d    = r_tx_data_q;
        w_tx_start_d   = 1'b0;
        w_timeout_d    = 1'b0;
        w_settle_cnt_d = r_settle_cnt_q;
        w_to_cnt_d     = r_to_cnt_q;
        w_drop         = 1'b0;

        case (r_state_q)
            S_WAIT_A: begin
                if (i_rx_valid) begin
                    w_data_bus_d = i_rx_data;
                    w_load_a_d   = 1'b1;
                    w_state_d    = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                w_drop    = i_rx_valid;
                w_state_d = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (i_rx_valid) begin
                    w_data_bus_d = i_rx_data;
                    w_load_b_d   = 1'b1;
                    w_state_d    = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                w_drop    = i_rx_valid;
                w_state_d = S_WAIT_OP;
            end
            S_WAIT_OP: begin
                if (i_rx_valid) begin
                    w_data_bus_d = i_rx_data & c_op_mask;
                    w_load_op_d  = 1'b1;
                    w_state_d    = S_LOAD_OP;
                end
            end
            S_LOAD_OP: begin
                w_drop         = i_rx_valid;
                w_settle_cnt_d = 4'd0;
                w_state_d      = S_SETTLE;
            end
            S_SETTLE: begin
                w_drop = i_rx_valid;
                if (r_settle_cnt_q == c_settle_last) begin
                    // Result is sampled on the same edge that raises tx_start.
                    w_tx_data_d    = i_result;
                    w_tx_start_d   = 1'b1;
                    w_settle_cnt_d = 4'd0;
                    w_state_d      = S_SEND;
                end else begin
                    w_settle_cnt_d = r_settle_cnt_q + 4'd1;
                end
            end
            S_SEND: begin
                w_drop     = i_rx_valid;
                w_to_cnt_d = '0;
                w_state_d  = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (i_tx_done) begin
                    // Done wins over timeout; a byte arriving with done is
                    // already the next command's operand A.
                    if (i_rx_valid) begin
                        w_data_bus_d = i_rx_data;
                        w_load_a_d   = 1'b1;
                        w_state_d    = S_LOAD_A;
                    end else begin
                        w_state_d    = S_WAIT_A;
                    end
                end else begin
                    w_drop = i_rx_valid;
                    if (r_to_cnt_q == c_to_last) begin
                        w_timeout_d = 1'b1;
                        w_state_d   = S_WAIT_A;
                    end else begin
                        w_to_cnt_d  = r_to_cnt_q + c_to_w'(1);
                    end
                end
            end
            default: begin
                w_state_d = S_WAIT_A;
            end
        endcase

        w_overrun_d = r_overrun_q | w_drop;
        w_busy_d    = (w_state_d != S_WAIT_A);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state_q      <= S_WAIT_A;
            r_data_bus_q   <= '0;
            r_load_a_q     <= 1'b0;
            r_load_b_q     <= 1'b0;
            r_load_op_q    <= 1'b0;
            r_tx_data_q    <= '0;
            r_tx_start_q   <= 1'b0;
            r_busy_q       <= 1'b0;
            r_overrun_q    <= 1'b0;
            r_timeout_q    <= 1'b0;
            r_settle_cnt_q <= 4'd0;
            r_to_cnt_q     <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_data_bus_q   <= w_data_bus_d;
            r_load_a_q     <= w_load_a_d;
            r_load_b_q     <= w_load_b_d;
            r_load_op_q    <= w_load_op_d;
            r_tx_data_q    <= w_tx_data_d;
            r_tx_start_q   <= w_tx_start_d;
            r_busy_q       <= w_busy_d;
            r_overrun_q    <= w_overrun_d;
            r_timeout_q    <= w_timeout_d;
            r_settle_cnt_q <= w_settle_cnt_d;
            r_to_cnt_q     <= w_to_cnt_d;
        end
    end

    assign o_data_bus = r_data_bus_q;
    assign o_load_A   = r_load_a_q;
    assign o_load_B   = r_load_b_q;
    assign o_load_op  = r_load_op_q;
    assign o_tx_data  = r_tx_data_q;
    assign o_tx_start = r_tx_start_q;
    assign o_busy     = r_busy_q;
    assign o_overrun  = r_overrun_q;
    assign o_timeout  = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Self-checking bench for alu_cmd_sequencer with a small ALU
//                model on the load interface and a command-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int DW = 8;
    localparam int SC = 2;
    localparam int TT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] result;
    logic          tx_done;
    logic [DW-1:0] data_bus;
    logic          load_a, load_b, load_op;
    logic [DW-1:0] tx_data;
    logic          tx_start, busy, overrun, timeout;

    alu_cmd_sequencer #(
        .DATA_WIDTH    (DW),
        .MODE_WIDTH    (6),
        .SETTLE_CYCLES (SC),
        .TX_TIMEOUT    (TT)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .i_result   (result),
        .i_tx_done  (tx_done),
        .o_data_bus (data_bus),
        .o_load_A   (load_a),
        .o_load_B   (load_b),
        .o_load_op  (load_op),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .o_busy     (busy),
        .o_overrun  (overrun),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Reference ALU behaviour for the opcodes exercised here.
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // ALU model: latches the bus on each load strobe edge.
    logic [7:0] alu_a = 8'h00, alu_b = 8'h00;
    logic [5:0] alu_op = 6'h00;
    always @(posedge clk) begin
        if (load_a)  alu_a  <= data_bus;
        if (load_b)  alu_b  <= data_bus;
        if (load_op) alu_op <= data_bus[5:0];
    end
    assign result = alu_ref(alu_a, alu_b, alu_op);

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_bus     = 8'h00;
    logic [7:0] exp_tx      = 8'h00;
    logic       exp_ovr     = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        tx_done  = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic la, input logic lb,
                             input logic lo, input logic ts, input logic to,
                             input logic bz);
        logic [22:0] obs, exp;
        obs = {load_a, load_b, load_op, tx_start, timeout, busy, overrun, data_bus, tx_data};
        exp = {la, lb, lo, ts, to, bz, exp_ovr, exp_bus, exp_tx};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (ldA ldB ldOp txs tmo busy ovr bus txd)",
                   tag, obs, exp);
        end
    endtask

    // Idle cycles in a WAIT state; stray tx_done pulses must be ignored.
    task automatic gap(input int n, input logic bz);
        for (int i = 0; i < n; i++) begin
            tx_done = 1'($urandom_range(0, 1));
            tick;
            check_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bz);
        end
    endtask

    // which: 0 = A, 1 = B, 2 = opcode
    task automatic load_byte(input int which, input logic [7:0] val, input string tag);
        rx_data  = val;
        rx_valid = 1'b1;
        tick;
        exp_bus = (which == 2) ? (val & 8'h3F) : val;
        check_all(tag, which == 0, which == 1, which == 2, 1'b0, 1'b0, 1'b1);
        tick;
        check_all({tag, "_end"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // ovr: 0 none, 1 drop during SETTLE, 2 drop during WAIT_TX
    // fin: 0 done, 1 timeout, 2 done + next A byte, 3 done on expiry cycle
    task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int ovr, input int fin, input logic [7:0] nexta,
                          input logic a_pre);
        logic [7:0] exp_res;
        int         w;
        exp_res = alu_ref(a, b, op[5:0]);
        if (!a_pre) begin
            gap($urandom_range(0, 2), 1'b0);
            load_byte(0, a, "load_A");
        end
        gap($urandom_range(0, 2), 1'b1);
        load_byte(1, b, "load_B");
        gap($urandom_range(0, 2), 1'b1);
        load_byte(2, op, "load_op");
        // first SETTLE cycle
        if (ovr == 1) begin
            rx_data  = 8'h55;
            rx_valid = 1'b1;
            exp_ovr  = 1'b1;
        end
        tick;
        check_all("settle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        exp_tx = exp_res;
        check_all("tx_start", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;
        check_all("wait_tx", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (ovr == 2) begin
            rx_data  = 8'h55;
            rx_valid = 1'b1;
            exp_ovr  = 1'b1;
        end
        if (fin == 0 || fin == 2) begin
            w = $urandom_range((ovr == 2) ? 1 : 0, 3);
            for (int i = 0; i < w; i++) begin
                tick;
                check_all("wait_tx_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            tx_done = 1'b1;
            if (fin == 2) begin
                rx_data  = nexta;
                rx_valid = 1'b1;
                tick;
                exp_bus = nexta;
                check_all("done_rx_A", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                tick;
                check_all("done_rx_A_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                tick;
                check_all("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end else begin
            // WAIT_TX occupies the 7 cycles after SEND; expiry lands 8 after it.
            for (int i = 0; i < TT - 2; i++) begin
                tick;
                check_all("wait_tx_to", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            if (fin == 3) begin
                tx_done = 1'b1;
                tick;
                check_all("done_vs_timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                tick;
                check_all("timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                tick;
                check_all("timeout_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        logic [7:0] a, b, op, na;
        logic       pre;
        int         fin, ovr;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // nominal add
        do_cmd(8'h05, 8'h03, 8'h20, 0, 0, 8'h00, 1'b0);
        // signed operands and opcode masking
        do_cmd(8'hFF, 8'h01, 8'hE0, 0, 0, 8'h00, 1'b0);
        // byte dropped during SETTLE
        do_cmd(8'h0A, 8'h0B, 8'h20, 1, 0, 8'h00, 1'b0);
        // transmit timeout, then done racing the expiry cycle
        do_cmd(8'h12, 8'h34, 8'h22, 0, 1, 8'h00, 1'b0);
        do_cmd(8'h5A, 8'h0F, 8'h24, 0, 3, 8'h00, 1'b0);

        // asynchronous reset with B still pending
        gap(1, 1'b0);
        load_byte(0, 8'h11, "rst_load_A");
        #2;
        rst = 1'b1;
        #1;
        exp_bus = 8'h00;
        exp_tx  = 8'h00;
        exp_ovr = 1'b0;
        check_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        check_all("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        do_cmd(8'h02, 8'h04, 8'h20, 0, 0, 8'h00, 1'b0);

        // done and the next A byte in the same cycle
        do_cmd(8'h09, 8'h09, 8'h20, 0, 2, 8'h07, 1'b0);
        do_cmd(8'h07, 8'h01, 8'h22, 0, 0, 8'h00, 1'b1);

        // byte dropped in WAIT_TX
        do_cmd(8'h33, 8'h44, 8'h26, 2, 0, 8'h00, 1'b0);

        // randomized commands
        pre = 1'b0;
        na  = 8'h00;
        for (int k = 0; k < 30; k++) begin
            a       = pre ? na : 8'($urandom);
            b       = 8'($urandom);
            op      = 8'($urandom);
            op[5:0] = 6'h20 + 6'(2 * $urandom_range(0, 3));
            fin     = $urandom_range(0, 3);
            ovr     = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            na      = 8'($urandom);
            do_cmd(a, b, op, ovr, fin, na, pre);
            pre = (fin == 2);
        end
        if (pre) do_cmd(na, 8'h01, 8'h20, 0, 0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command sequencer that drives the ALU top module's load interface from a serial byte stream. It captures three bytes (operand A, operand B, opcode) from the receive side and replays each one onto the ALU data bus with a one-cycle load strobe. After a settle window it hands the ALU result to the transmit side. It sits between the UART receiver/transmitter pair and the ALU, replacing manual switch/button loading.

## Interface
- DATA_WIDTH, 8, operand/result width; also the byte width on rx/tx.
- MODE_WIDTH, 6, opcode width; the ALU opcode is the low MODE_WIDTH bits of the op byte.
- SETTLE_CYCLES, 2, cycles between the op load strobe and result capture; legal range 1..15.
- TX_TIMEOUT, 1024, maximum cycles spent waiting for i_tx_done; must be ≥ 2.
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_data  in  DATA_WIDTH  received byte; valid only when i_rx_valid is high.
- i_rx_valid  in  1  one-cycle pulse per received byte.
- i_result  in  DATA_WIDTH  ALU result, signed.
- i_tx_done  in  1  one-cycle pulse when the transmitter has finished a byte.
- o_data_bus  out  DATA_WIDTH  data bus to the ALU.
- o_load_A, o_load_B, o_load_op  out  1 each  one-cycle load strobes to the ALU.
- o_tx_data  out  DATA_WIDTH  result byte presented to the transmitter.
- o_tx_start  out  1  one-cycle transmit request.
- o_busy  out  1  high in every state except WAIT_A.
- o_overrun  out  1  sticky flag; set when a byte is dropped; cleared only by reset.
- o_timeout  out  1  one-cycle pulse when a transmit timeout is abandoned.

## Operation
- States: WAIT_A, LOAD_A, WAIT_B, LOAD_B, WAIT_OP, LOAD_OP, SETTLE, SEND, WAIT_TX.
- WAIT_x + i_rx_valid:
  - Capture i_rx_data into the internal byte register.
  - Next state is LOAD_x.
- LOAD_x, one cycle:
  - o_data_bus = captured byte and the matching o_load_x = 1.
  - Next state: LOAD_A→WAIT_B, LOAD_B→WAIT_OP, LOAD_op→SETTLE.
- Op byte: o_data_bus = {zeros, byte[MODE_WIDTH-1:0]}. Upper bits are forced to 0 and the opcode is not validated.
- o_data_bus holds its last driven value outside LOAD states. It changes only on entry to a LOAD state.
- SETTLE: counts SETTLE_CYCLES cycles, then moves to SEND.
- SEND, one cycle:
  - o_tx_data ← i_result, o_tx_start = 1.
  - Next state is WAIT_TX, and the timeout counter is cleared.
- WAIT_TX:
  - i_tx_done → WAIT_A.
  - Counter reaches TX_TIMEOUT-1 with no done → WAIT_A with o_timeout = 1 for one cycle.
- Byte drop rule: i_rx_valid in LOAD_x, SETTLE, SEND or WAIT_TX sets o_overrun and the byte is discarded. The one exception follows.
- Simultaneous events in WAIT_TX:
  - i_tx_done and i_rx_valid in the same cycle: the byte is accepted as operand A. Next state is LOAD_A, no overrun.
  - i_tx_done and timeout expiry in the same cycle: done wins and o_timeout stays 0.
- i_tx_done outside WAIT_TX is ignored.
- o_tx_data holds its value until the next SEND.

## Timing
- All outputs are registered.
- Reset values:
  - State WAIT_A.
  - o_data_bus = 0, o_load_A/B/op = 0, o_tx_data = 0, o_tx_start = 0.
  - o_busy = 0, o_overrun = 0, o_timeout = 0.
  - Settle and timeout counters = 0.
- Reset mid-sequence: all outputs return to their reset values asynchronously. Partially collected operands are discarded, and the next byte is treated as A.
- Latency from i_rx_valid (cycle N) to o_load_x high: cycle N+1. The strobe is exactly one cycle wide.
- o_data_bus is valid in the same cycle as the strobe and stays stable afterwards. The ALU samples it on the strobe edge.
- o_tx_start fires on cycle M+1+SETTLE_CYCLES, where M is the o_load_op cycle. i_result is sampled on that same edge.
- Minimum back-to-back command cycle: SETTLE_CYCLES plus 6 cycles plus the transmit time.

## Test plan
- Nominal add: bytes 0x05, 0x03, 0x20 (ADD) with an ALU model.
  - Strobes appear in the order load_A (bus 0x05), load_B (0x03), load_op (0x20), each one cycle after its rx_valid.
  - o_tx_start fires 3 cycles after load_op with o_tx_data = 0x08.
  - Drive i_tx_done: o_busy drops the next cycle.
- Signed/opcode masking: bytes 0xFF, 0x01, 0xE0.
  - Op bus = 0x20, upper bits masked.
  - ADD result 0x00 is transmitted.
- Overrun: extra i_rx_valid (0x55) during SETTLE.
  - o_overrun = 1 and stays set.
  - The bus never shows 0x55 and the sequence completes normally.
- Timeout with TX_TIMEOUT = 8: never assert i_tx_done.
  - o_timeout pulses 8 cycles after SEND.
  - State returns to WAIT_A; a new A byte is accepted.
- Reset mid-operation: assert i_rst after load_A (0x11) with B still pending.
  - All outputs go to 0.
  - Following bytes 0x02, 0x04, 0x20 load as A, B, op; result 0x06.
- Simultaneous event: i_tx_done and i_rx_valid (0x07) in the same cycle in WAIT_TX.
  - load_A with bus 0x07 occurs the next cycle.
  - o_overrun stays 0.
